// File: rtl/pipe_sched.sv
// pipe_sched: merges decode stall requests with multi-cycle EX sequencing
// (MADD-class phase counter, divider start/cancel) into a per-stage stall vector.
// Latency: all outputs combinational from state + inputs; state/cnt registered.
// Backpressure: stall_o holds PC..EX while a multi-cycle op runs; flush overrides.
//
// Ports:
//   clk, rst (async active-low)          clock / reset
//   stallreq_id_i                        decode stall request (level)
//   ex_mc_req_i, ex_mc_kind_i            multi-cycle op in EX (0 = MADD, 1 = DIV)
//   flush_i                              aborts any sequence
//   div_ready_i                          divider result strobe
//   stall_o[5:0]                         {WB,MEM,EX,ID,IF,PC}, 1 = hold
//   cnt_o[1:0]                           MADD phase index
//   div_start_o, div_cancel_o            divider handshake pulses
//   ex_mc_done_o                         EX result valid this cycle
//   busy_o, mc_err_o                     sequencer busy / divide timeout
//
// Optional feature: define PIPE_SCHED_WATCHDOG_EN to add the divide watchdog.

module pipe_sched #(
  parameter int MADD_CYCLES = 2,
  parameter int DIV_CYCLES  = 33
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stallreq_id_i,
  input  logic       ex_mc_req_i,
  input  logic       ex_mc_kind_i,
  input  logic       flush_i,
  input  logic       div_ready_i,
  output logic [5:0] stall_o,
  output logic [1:0] cnt_o,
  output logic       div_start_o,
  output logic       div_cancel_o,
  output logic       ex_mc_done_o,
  output logic       busy_o,
  output logic       mc_err_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MADD = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

  localparam logic [5:0] STALL_EX = 6'b001111;  // PC, IF, ID, EX held
  localparam logic [5:0] STALL_ID = 6'b000111;  // PC, IF, ID held
  localparam logic [1:0] CNT_LAST = 2'(MADD_CYCLES - 1);

  // The phase counter is two bits wide and the watchdog eight bits wide.
  if (MADD_CYCLES < 2 || MADD_CYCLES > 4 || DIV_CYCLES < 1 || 2 * DIV_CYCLES > 255) begin : g_bad_params
    $error("pipe_sched: parameter out of range");
  end

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       wdog_trip;

  logic       ex_stall;
  logic       done;
  logic       start;
  logic       cancel;
  logic       err;

`ifdef PIPE_SCHED_WATCHDOG_EN
  localparam logic [7:0] WDOG_LIMIT = 8'(2 * DIV_CYCLES);

  // wdog_q counts cycles since div_start_o: 1 in the first DIV cycle, so the
  // trip lands DIV_CYCLES*2 cycles after the start pulse.
  logic [7:0] wdog_q, wdog_d;

  always_comb begin
    wdog_d = '0;
    if (state_d == ST_DIV) begin
      wdog_d = (state_q == ST_DIV) ? wdog_q + 8'd1 : 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end

  assign wdog_trip = (state_q == ST_DIV) && (wdog_q == WDOG_LIMIT);
`else
  assign wdog_trip = 1'b0;
`endif

  // Next state and raw strobes; flush is applied afterwards as an override.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ex_stall = 1'b0;
    done     = 1'b0;
    start    = 1'b0;
    cancel   = 1'b0;
    err      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (ex_mc_req_i) begin
          ex_stall = 1'b1;
          if (ex_mc_kind_i) begin
            start   = 1'b1;
            state_d = ST_DIV;
          end else begin
            state_d = ST_MADD;
            cnt_d   = 2'd1;
          end
        end
      end

      ST_MADD: begin
        if (cnt_q == CNT_LAST) begin
          // Done cycle is never IDLE, so a held request cannot retrigger.
          done    = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          ex_stall = 1'b1;
          cnt_d    = cnt_q + 2'd1;
        end
      end

      ST_DIV: begin
        if (div_ready_i) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end else if (wdog_trip) begin
          done    = 1'b1;
          cancel  = 1'b1;
          err     = 1'b1;
          state_d = ST_IDLE;
        end else begin
          ex_stall = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (flush_i) begin
      cancel   = (state_q == ST_DIV);
      state_d  = ST_IDLE;
      cnt_d    = '0;
      ex_stall = 1'b0;
      done     = 1'b0;
      start    = 1'b0;
      err      = 1'b0;
    end
  end

  // Output stage: every output is forced low while reset is held, so a
  // reset taken mid-divide never produces a cancel pulse.
  always_comb begin
    stall_o      = '0;
    cnt_o        = '0;
    div_start_o  = 1'b0;
    div_cancel_o = 1'b0;
    ex_mc_done_o = 1'b0;
    busy_o       = 1'b0;
    mc_err_o     = 1'b0;
    if (rst) begin
      if (flush_i) begin
        stall_o = '0;
      end else if (ex_stall) begin
        stall_o = STALL_EX;
      end else if (stallreq_id_i) begin
        stall_o = STALL_ID;
      end
      cnt_o        = cnt_q;
      div_start_o  = start;
      div_cancel_o = cancel;
      ex_mc_done_o = done;
      busy_o       = (state_q != ST_IDLE);
      mc_err_o     = err;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_sched.sv
module tb_pipe_sched;

  localparam int MADD_CYCLES = 2;
  localparam int DIV_CYCLES  = 33;
`ifdef PIPE_SCHED_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       stallreq_id_i, ex_mc_req_i, ex_mc_kind_i, flush_i, div_ready_i;
  logic [5:0] stall_o;
  logic [1:0] cnt_o;
  logic       div_start_o, div_cancel_o, ex_mc_done_o, busy_o, mc_err_o;

  always #5 clk = ~clk;

  pipe_sched #(.MADD_CYCLES(MADD_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_id_i(stallreq_id_i),
    .ex_mc_req_i  (ex_mc_req_i),
    .ex_mc_kind_i (ex_mc_kind_i),
    .flush_i      (flush_i),
    .div_ready_i  (div_ready_i),
    .stall_o      (stall_o),
    .cnt_o        (cnt_o),
    .div_start_o  (div_start_o),
    .div_cancel_o (div_cancel_o),
    .ex_mc_done_o (ex_mc_done_o),
    .busy_o       (busy_o),
    .mc_err_o     (mc_err_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: an operation in flight is described by its kind and its
  // age (cycles since the request cycle, which is age 0).
  bit m_busy = 1'b0;
  bit m_div  = 1'b0;
  int m_age  = 0;

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"},  {2'b0, stall_o}, 8'h00);
    check({tag, "_cnt"},    {6'b0, cnt_o},   8'h00);
    check({tag, "_start"},  {7'b0, div_start_o},  8'h00);
    check({tag, "_cancel"}, {7'b0, div_cancel_o}, 8'h00);
    check({tag, "_done"},   {7'b0, ex_mc_done_o}, 8'h00);
    check({tag, "_busy"},   {7'b0, busy_o},       8'h00);
    check({tag, "_err"},    {7'b0, mc_err_o},     8'h00);
  endtask

  // Drives one cycle of inputs, checks every output against the model, then
  // advances the model. Returns before the next rising edge.
  task automatic cycle(input bit req, input bit kind, input bit flush, input bit ready, input bit sid);
    logic [5:0] e_stall;
    logic [1:0] e_cnt;
    bit e_start, e_cancel, e_done, e_err, ex;
    @(negedge clk);
    ex_mc_req_i   = req;
    ex_mc_kind_i  = kind;
    flush_i       = flush;
    div_ready_i   = ready;
    stallreq_id_i = sid;
    #1;
    e_cnt = 2'd0; e_start = 0; e_cancel = 0; e_done = 0; e_err = 0; ex = 0;
    if (!m_busy) begin
      if (req) begin
        ex = 1;
        e_start = kind;
      end
    end else if (!m_div) begin
      e_cnt = 2'(m_age);
      if (m_age == MADD_CYCLES - 1) e_done = 1;
      else ex = 1;
    end else begin
      if (ready) e_done = 1;
      else if (WD && m_age == 2 * DIV_CYCLES) begin
        e_done = 1; e_cancel = 1; e_err = 1;
      end else ex = 1;
    end
    if (flush) begin
      e_cancel = m_busy && m_div;
      ex = 0; e_done = 0; e_start = 0; e_err = 0;
      e_stall = 6'b000000;
    end else if (ex) e_stall = 6'b001111;
    else if (sid)    e_stall = 6'b000111;
    else             e_stall = 6'b000000;

    check("stall",  {2'b0, stall_o},      {2'b0, e_stall});
    check("cnt",    {6'b0, cnt_o},        {6'b0, e_cnt});
    check("start",  {7'b0, div_start_o},  {7'b0, e_start});
    check("cancel", {7'b0, div_cancel_o}, {7'b0, e_cancel});
    check("done",   {7'b0, ex_mc_done_o}, {7'b0, e_done});
    check("busy",   {7'b0, busy_o},       {7'b0, m_busy});
    check("err",    {7'b0, mc_err_o},     {7'b0, e_err});

    if (flush) m_busy = 0;
    else if (!m_busy) begin
      if (req) begin m_busy = 1; m_div = kind; m_age = 1; end
    end else if (e_done) m_busy = 0;
    else m_age++;
  endtask

  initial begin
    // Reset held with active-looking inputs: outputs must all be 0.
    rst = 1'b0;
    ex_mc_req_i = 1; ex_mc_kind_i = 1; flush_i = 0; div_ready_i = 0; stallreq_id_i = 1;
    #12;
    check_all_zero("rst_hold");
    @(negedge clk);
    ex_mc_req_i = 0; ex_mc_kind_i = 0; stallreq_id_i = 0;
    rst = 1'b1;

    cycle(0, 0, 0, 0, 0);
    check("idle_stall", {2'b0, stall_o}, 8'h00);
    check("idle_busy", {7'b0, busy_o}, 8'h00);

    // MADD, request held two cycles.
    cycle(1, 0, 0, 0, 0);
    check("madd_c0_stall", {2'b0, stall_o}, 8'h0f);
    check("madd_c0_cnt", {6'b0, cnt_o}, 8'h00);
    cycle(1, 0, 0, 0, 0);
    check("madd_c1_cnt", {6'b0, cnt_o}, 8'h01);
    check("madd_c1_done", {7'b0, ex_mc_done_o}, 8'h01);
    check("madd_c1_stall", {2'b0, stall_o}, 8'h00);
    cycle(0, 0, 0, 0, 0);
    check("madd_c2_busy", {7'b0, busy_o}, 8'h00);

    // Divide, ready 33 cycles after start.
    cycle(1, 1, 0, 0, 0);
    check("div_c0_start", {7'b0, div_start_o}, 8'h01);
    for (int i = 1; i <= 32; i++) begin
      cycle(1, 1, 0, 0, 0);
      check("div_wait_start", {7'b0, div_start_o}, 8'h00);
      check("div_wait_stall", {2'b0, stall_o}, 8'h0f);
    end
    cycle(1, 1, 0, 1, 0);
    check("div_c33_done", {7'b0, ex_mc_done_o}, 8'h01);
    check("div_c33_stall", {2'b0, stall_o}, 8'h00);
    cycle(0, 0, 0, 0, 0);

    // Divide flushed at cycle 5; late ready ignored.
    cycle(1, 1, 0, 0, 0);
    for (int i = 1; i < 5; i++) cycle(1, 1, 0, 0, 0);
    cycle(1, 1, 1, 0, 0);
    check("flush_cancel", {7'b0, div_cancel_o}, 8'h01);
    check("flush_stall", {2'b0, stall_o}, 8'h00);
    cycle(0, 0, 0, 0, 0);
    check("flush_next_busy", {7'b0, busy_o}, 8'h00);
    cycle(0, 0, 0, 1, 0);
    check("late_ready_done", {7'b0, ex_mc_done_o}, 8'h00);

    // Decode stall alone, then merged with a MADD.
    cycle(0, 0, 0, 0, 1);
    check("id_only_stall", {2'b0, stall_o}, 8'h07);
    cycle(1, 0, 0, 0, 1);
    check("id_madd_stall", {2'b0, stall_o}, 8'h0f);
    cycle(0, 0, 0, 0, 1);
    check("id_madd_done_stall", {2'b0, stall_o}, 8'h07);

    // Flush during MADD.
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 1, 0, 1);
    check("madd_flush_done", {7'b0, ex_mc_done_o}, 8'h00);
    check("madd_flush_cancel", {7'b0, div_cancel_o}, 8'h00);
    cycle(0, 0, 0, 0, 0);

    // Divide with no ready.
    cycle(1, 1, 0, 0, 0);
`ifdef PIPE_SCHED_WATCHDOG_EN
    for (int i = 1; i < 66; i++) cycle(1, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    check("wd_err", {7'b0, mc_err_o}, 8'h01);
    check("wd_cancel", {7'b0, div_cancel_o}, 8'h01);
    check("wd_done", {7'b0, ex_mc_done_o}, 8'h01);
    cycle(0, 0, 0, 0, 0);
    check("wd_next_busy", {7'b0, busy_o}, 8'h00);
`else
    for (int i = 1; i < 80; i++) cycle(1, 1, 0, 0, 0);
    check("nowd_busy", {7'b0, busy_o}, 8'h01);
    check("nowd_err", {7'b0, mc_err_o}, 8'h00);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0);
`endif

    // Reset mid-divide: no cancel pulse, everything 0.
    cycle(1, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all_zero("rst_mid_div");
    m_busy = 0;
    @(negedge clk);
    ex_mc_req_i = 0; ex_mc_kind_i = 0;
    rst = 1'b1;
    cycle(0, 0, 0, 0, 0);
    check("post_rst_busy", {7'b0, busy_o}, 8'h00);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom % 3) != 0, ($urandom % 2) == 1, ($urandom % 24) == 0,
            ($urandom % 12) == 0, ($urandom % 4) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_sched.md
# pipe_sched

Pipeline stall scheduler for the five-stage core. It merges decode-stage stall requests with multi-cycle execute operations (MADD/MSUB-class two-phase accumulate, iterative divide) and produces the per-stage stall vector. It sequences the EX-stage phase counter and the divider start/cancel handshake, and sits beside the pipeline registers, driving their stall inputs.

## Interface
- MADD_CYCLES, 2 — total EX cycles for a MADD-class op (≥2)
- DIV_CYCLES, 33 — nominal divider latency in cycles from `div_start_o`; used only by the watchdog
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-low (0 = reset)
- stallreq_id_i  input  1  decode-stage stall request (level)
- ex_mc_req_i  input  1  instruction in EX is multi-cycle (level, held while instruction stays in EX)
- ex_mc_kind_i  input  1  0 = MADD-class, 1 = divide; sampled with `ex_mc_req_i` in IDLE
- flush_i  input  1  pipeline flush; aborts any sequence
- div_ready_i  input  1  divider result valid (one-cycle strobe)
- stall_o  output  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = hold
- cnt_o  output  2  MADD-class phase index to EX
- div_start_o  output  1  one-cycle divider start pulse
- div_cancel_o  output  1  one-cycle divider abort pulse
- ex_mc_done_o  output  1  one-cycle strobe: EX result valid this cycle
- busy_o  output  1  state ≠ IDLE
- mc_err_o  output  1  divide timed out (only with watchdog)

## Operation
- States: IDLE, MADD, DIV.
- IDLE, `ex_mc_req_i` = 1, kind 0: `cnt_o` = 0, stall_o = 6'b001111, next MADD with cnt = 1.
- IDLE, `ex_mc_req_i` = 1, kind 1: `div_start_o` = 1, stall_o = 6'b001111, next DIV.
- MADD: `cnt_o` = cnt. If cnt < MADD_CYCLES-1: stall 6'b001111, cnt increments. If cnt = MADD_CYCLES-1: `ex_mc_done_o` = 1, EX stall released, next IDLE, cnt cleared.
- DIV: stall 6'b001111 until `div_ready_i`. Cycle with `div_ready_i` = 1: `ex_mc_done_o` = 1, EX stall released, next IDLE.
- `div_ready_i` outside DIV: ignored.
- No EX stall pending and `stallreq_id_i` = 1: stall_o = 6'b000111. EX stall is a superset and wins.
- `flush_i` = 1, any state: stall_o = 0, `ex_mc_done_o` = 0, next IDLE, cnt = 0. In DIV, `div_cancel_o` = 1. In IDLE, flush suppresses `div_start_o` and entry into MADD/DIV.
- The done cycle is never IDLE, so a held `ex_mc_req_i` cannot retrigger the same instruction. A new multi-cycle op may start the cycle after done.

## Timing
- `stall_o`, `cnt_o`, `div_start_o`, `div_cancel_o`, `ex_mc_done_o`, and `mc_err_o` are combinational from state and inputs. State and cnt are registered.
- MADD-class: EX occupies MADD_CYCLES cycles; stall asserted for the first MADD_CYCLES-1 of them.
- Divide: stall from the request cycle through the cycle before `div_ready_i`. Done is coincident with `div_ready_i`, zero added latency.
- Reset (asynchronous assert, synchronous release): state IDLE, cnt 0, watchdog 0. All outputs are 0 while `rst` = 0.
- Reset mid-DIV: no `div_cancel_o` is issued. The divider shares `rst`.

## Configuration
- `PIPE_SCHED_WATCHDOG_EN` defined: an 8-bit counter clears on DIV entry and increments each DIV cycle. When it reaches 2*DIV_CYCLES without `div_ready_i`, in that cycle: `div_cancel_o` = 1, `ex_mc_done_o` = 1, `mc_err_o` = 1, next IDLE.
- Undefined: no counter. DIV waits indefinitely and `mc_err_o` is tied 0.

## Test plan
- Reset released, all inputs 0: `stall_o` = 0, `busy_o` = 0, all strobes 0.
- `ex_mc_req_i` = 1, kind 0, held two cycles, MADD_CYCLES = 2: cycle 0 `stall_o` = 001111 and `cnt_o` = 0; cycle 1 `cnt_o` = 1, `ex_mc_done_o` = 1, `stall_o` = 0; cycle 2 IDLE.
- Divide request, `div_ready_i` pulsed 33 cycles later: `div_start_o` is a single pulse at cycle 0; `stall_o` = 001111 for cycles 0–32; cycle 33 has done = 1 and `stall_o` = 0.
- Divide in progress, `flush_i` at cycle 5: `div_cancel_o` = 1 and `stall_o` = 0 that cycle; `busy_o` = 0 next cycle; a later `div_ready_i` is ignored.
- `stallreq_id_i` = 1 alone gives `stall_o` = 000111. Asserted during MADD stall it gives 001111.
- With watchdog enabled, DIV_CYCLES = 33, no ready: at DIV cycle 66, `mc_err_o`, `div_cancel_o`, and `ex_mc_done_o` are 1; next cycle is IDLE.
